bcp_cmd_sequencer: RTL and testbench
====================================

Name: bcp_cmd_sequencer

Overview:
- AXI4-Lite master that turns one high-level BCP command into the register write sequence the BCP accelerator's S01 AXI slave expects.
- Two command types: clause update (reg0 clear, reg1..reg3 literals, reg0 = {clause_id, 01}) and decision (reg0 clear, reg1 literal, reg0 = 0x2).
- Sits between the host-side command source (CPU shim/FIFO) and the accelerator slave; owns write ordering, per-write handshakes, inter-write spacing and error reporting.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width (fixed at 32; literal format {var[30:0], pol}).
- BASE_ADDR, 32'h0, slave base; reg0..reg3 at BASE_ADDR + 0x0/0x4/0x8/0xC.
- GAP_CYCLES, 2, idle cycles inserted between consecutive writes of one command (0 = none).

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  1 = clause update, 2 = decision, 0/3 illegal
- cmd_clause_id  in  30  clause index (clause update only)
- cmd_lit1, cmd_lit2, cmd_lit3  in  32 each  literals {var[30:0], polarity}; decision uses lit1 only
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  2  status with done: 00 ok, 01 slave BRESP error, 10 illegal op
- M_AXI_AWADDR  out  32 / M_AXI_AWPROT  out  3 / M_AXI_AWVALID  out  1 / M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32 / M_AXI_WSTRB  out  4 / M_AXI_WVALID  out  1 / M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2 / M_AXI_BVALID  in  1 / M_AXI_BREADY  out  1

Behaviour:
- Reset (ARESETN low at a clock edge): state IDLE; cmd_ready = 1 after reset; busy, done, AWVALID, WVALID and BREADY = 0; err = 00; AWADDR/WDATA = 0; WSTRB = 0; step and gap counters = 0.
- Reset mid-command aborts the command immediately; no done pulse. The slave is reset together with the sequencer.
- AWPROT is always 3'b000.
- States: IDLE, ISSUE, RESP, GAP, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch all cmd fields, step = 0, go to ISSUE.
  - Illegal op: go to DONE with err = 10 and issue no writes.
- Step tables:
  - Clause update: 5 steps: (reg0, 0), (reg1, lit1), (reg2, lit2), (reg3, lit3), (reg0, {clause_id, 2'b01}).
  - Decision: 3 steps: (reg0, 0), (reg1, lit1), (reg0, 32'h2).
- ISSUE:
  - AWVALID and WVALID both assert in the first ISSUE cycle, with AWADDR/WDATA from the step table and WSTRB = 4'hF.
  - Each valid deasserts on the edge where its own ready is sampled high. The two channels complete independently, in either order or in the same cycle.
  - Address and data stay stable while their valid is high.
  - Go to RESP once both handshakes are done. WSTRB returns to 0 at that point.
- RESP:
  - BREADY = 1. Wait for BVALID.
  - BRESP == 00: if this was the last step go to DONE, otherwise go to GAP (or straight to ISSUE when GAP_CYCLES = 0) with step + 1.
  - BRESP != 00: remaining steps are abandoned; go to DONE with err = 01.
- GAP: count GAP_CYCLES cycles with all AXI valids and BREADY low, then go to ISSUE.
- DONE: done = 1 for exactly one cycle with err valid, then IDLE. err holds its value until the next command is accepted.
- busy = 1 in every state except IDLE.
- No new command is accepted while busy; cmd_valid held high is accepted in the first IDLE cycle after DONE.
- Latency with an always-ready, 1-cycle-BVALID slave: each write = 1 ISSUE + 1 RESP cycle.
  - Clause update: 5×2 + 4×GAP_CYCLES + 1 (DONE) = 19 cycles from accept to done at GAP_CYCLES = 2.
  - Decision: 11 cycles at GAP_CYCLES = 2.
- Write responses are never overlapped: exactly one outstanding write at any time.

Test Plan:
- Clause 0 = {8, -9, 7}: op = 1, id = 0, lit = 0x11 / 0x12 / 0x0F, ready slave → writes (0x0, 0), (0x4, 0x11), (0x8, 0x12), (0xC, 0x0F), (0x0, 0x1); done after 19 cycles; err = 00.
- Decision var 1 true: op = 2, lit1 = 0x03 → writes (0x0, 0), (0x4, 0x3), (0x0, 0x2); done after 11 cycles; err = 00.
- Skewed handshakes: AWREADY 3 cycles late while WREADY is immediate, then the reverse → WVALID drops first / AWVALID drops first, each exactly one write, data unchanged; sequence completes.
- Slave returns BRESP = 10 on step 2 of a clause update → no writes to 0xC or the final reg0; done with err = 01.
- Illegal op = 3 → no AW/W activity; done 1 cycle after accept with err = 10.
- Reset asserted during RESP of step 3, then a new clause id = 5 {4, 19, 16} → all outputs at reset values; the new command runs its full 5-write sequence, ending with reg0 = 0x15.

Source files
------------

// File: rtl/bcp_cmd_sequencer.sv
// AXI4-Lite master that expands one BCP command (clause update or decision)
// into the ordered register write sequence of the accelerator slave.
module bcp_cmd_sequencer #(
    parameter int                          C_M_AXI_ADDR_WIDTH = 32,
    parameter int                          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int                          GAP_CYCLES         = 2
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [29:0]                     cmd_clause_id,
    input  logic [31:0]                     cmd_lit1,
    input  logic [31:0]                     cmd_lit2,
    input  logic [31:0]                     cmd_lit3,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RESP, S_GAP, S_DONE} state_t;

    localparam logic [1:0] OP_CLAUSE = 2'd1;
    localparam logic [1:0] OP_DECIDE = 2'd2;
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_SLV   = 2'b01;
    localparam logic [1:0] ERR_OP    = 2'b10;
    localparam int         GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t                          state_q, state_d;
    logic [2:0]                      step_q, step_d;
    logic [GW-1:0]                   gap_q, gap_d;
    logic [1:0]                      op_q, op_d;
    logic [29:0]                     id_q, id_d;
    logic [31:0]                     lit1_q, lit1_d, lit2_q, lit2_d, lit3_q, lit3_d;
    logic [1:0]                      err_q, err_d;
    logic                            awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                            load;

    // Register offset of a step: reg1..reg3 for the literals, reg0 otherwise
    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] step_off(input logic [1:0] op,
                                                               input logic [2:0] step);
        logic [C_M_AXI_ADDR_WIDTH-1:0] off;
        off = '0;
        if (step >= 3'd1 && step <= 3'd3 && !(op == OP_DECIDE && step != 3'd1))
            off = C_M_AXI_ADDR_WIDTH'({step, 2'b00});
        return off;
    endfunction

    // Write data of a step; the final reg0 write is the command trigger
    function automatic logic [31:0] step_data(input logic [1:0] op, input logic [2:0] step,
                                              input logic [29:0] id, input logic [31:0] l1,
                                              input logic [31:0] l2, input logic [31:0] l3);
        logic [31:0] d;
        d = 32'h0;
        case (step)
            3'd1:    d = l1;
            3'd2:    d = (op == OP_DECIDE) ? 32'h2 : l2;
            3'd3:    d = l3;
            3'd4:    d = {id, 2'b01};
            default: d = 32'h0;
        endcase
        return d;
    endfunction

    // Next-state, step sequencing and AXI channel control
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        gap_d     = gap_q;
        op_d      = op_q;
        id_d      = id_q;
        lit1_d    = lit1_q;
        lit2_d    = lit2_q;
        lit3_d    = lit3_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        load      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    id_d   = cmd_clause_id;
                    lit1_d = cmd_lit1;
                    lit2_d = cmd_lit2;
                    lit3_d = cmd_lit3;
                    step_d = 3'd0;
                    gap_d  = '0;
                    if (cmd_op == OP_CLAUSE || cmd_op == OP_DECIDE) begin
                        err_d   = ERR_OK;
                        state_d = S_ISSUE;
                        load    = 1'b1;
                    end else begin
                        err_d   = ERR_OP;
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                // each channel drops its valid on its own handshake
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
                    state_d = S_RESP;
                    wstrb_d = '0;
                end
            end
            S_RESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        err_d   = ERR_SLV;
                        state_d = S_DONE;
                    end else if (step_q == ((op_q == OP_CLAUSE) ? 3'd4 : 3'd2)) begin
                        state_d = S_DONE;
                    end else begin
                        step_d = step_q + 3'd1;
                        if (GAP_CYCLES == 0) begin
                            state_d = S_ISSUE;
                            load    = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_ISSUE;
                    load    = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // op_d/step_d already hold the values of the write being launched
        if (load) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = BASE_ADDR + step_off(op_d, step_d);
            wdata_d   = step_data(op_d, step_d, id_d, lit1_d, lit2_d, lit3_d);
            wstrb_d   = '1;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            gap_q     <= '0;
            op_q      <= '0;
            id_q      <= '0;
            lit1_q    <= '0;
            lit2_q    <= '0;
            lit3_q    <= '0;
            err_q     <= ERR_OK;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            gap_q     <= gap_d;
            op_q      <= op_d;
            id_q      <= id_d;
            lit1_q    <= lit1_d;
            lit2_q    <= lit2_d;
            lit3_q    <= lit3_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == S_RESP);

endmodule

// File: tb/tb_bcp_cmd_sequencer.sv
// Bench for bcp_cmd_sequencer: AXI-Lite slave model with programmable ready
// skew and error injection, directed cases plus randomized commands.
module tb_bcp_cmd_sequencer;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [29:0] cmd_clause_id = '0;
    logic [31:0] cmd_lit1 = '0, cmd_lit2 = '0, cmd_lit3 = '0;
    logic        busy, done;
    logic [1:0]  err;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  bresp;

    always #5 clk = ~clk;

    bcp_cmd_sequencer #(.GAP_CYCLES(GAP)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_clause_id(cmd_clause_id), .cmd_lit1(cmd_lit1), .cmd_lit2(cmd_lit2),
        .cmd_lit3(cmd_lit3), .busy(busy), .done(done), .err(err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, b_err_idx = -1;
    int          aw_wait = 0, w_wait = 0, aw_t = 0, w_t = 0, cyc = 0;
    int          stab_bad = 0, ovl_bad = 0;
    logic        got_aw = 1'b0, got_w = 1'b0, aw_held = 1'b0, w_held = 1'b0;
    logic [31:0] cap_addr = '0, cap_data = '0, aw_hold = '0, w_hold = '0;
    logic        bvalid_r = 1'b0;
    logic [1:0]  bresp_r = '0;
    logic [31:0] obs_addr[$], obs_data[$];
    int          obs_ord[$];

    assign awready = awvalid && (aw_wait >= aw_dly);
    assign wready  = wvalid && (w_wait >= w_dly);
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    wire aw_hs = awvalid && awready;
    wire w_hs  = wvalid && wready;

    // 0: same edge, 1: W handshake first, 2: AW handshake first
    function automatic int ord_of(input int a, input int w);
        return (a == w) ? 0 : ((w < a) ? 1 : 2);
    endfunction

    // Slave: records each completed write, answers with one-cycle BVALID
    always @(posedge clk) begin
        if (!rstn) begin
            got_aw <= 1'b0; got_w <= 1'b0; aw_held <= 1'b0; w_held <= 1'b0;
            aw_wait <= 0; w_wait <= 0; bvalid_r <= 1'b0; bresp_r <= 2'b00;
        end else begin
            cyc <= cyc + 1;
            if (awvalid && aw_held && awaddr !== aw_hold) stab_bad <= stab_bad + 1;
            if (wvalid && w_held && wdata !== w_hold)     stab_bad <= stab_bad + 1;
            if (awvalid && awprot !== 3'b000)             stab_bad <= stab_bad + 1;
            if (w_hs && wstrb !== 4'hF)                   stab_bad <= stab_bad + 1;
            if ((awvalid || wvalid) && bvalid_r)          ovl_bad <= ovl_bad + 1;
            if (aw_hs && got_aw)                          ovl_bad <= ovl_bad + 1;
            if (aw_hs) begin
                got_aw <= 1'b1; cap_addr <= awaddr; aw_wait <= 0; aw_t <= cyc; aw_held <= 1'b0;
            end else if (awvalid) begin
                aw_wait <= aw_wait + 1; aw_hold <= awaddr; aw_held <= 1'b1;
            end
            if (w_hs) begin
                got_w <= 1'b1; cap_data <= wdata; w_wait <= 0; w_t <= cyc; w_held <= 1'b0;
            end else if (wvalid) begin
                w_wait <= w_wait + 1; w_hold <= wdata; w_held <= 1'b1;
            end
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                bresp_r  <= (obs_addr.size() == b_err_idx) ? 2'b10 : 2'b00;
                bvalid_r <= 1'b1;
                obs_addr.push_back(aw_hs ? awaddr : cap_addr);
                obs_data.push_back(w_hs ? wdata : cap_data);
                obs_ord.push_back(ord_of(aw_hs ? cyc : aw_t, w_hs ? cyc : w_t));
                got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (bvalid_r && bready) bvalid_r <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int pass_cnt = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the write list a command should produce, from the command table
    logic [31:0] exp_a[5], exp_d[5];
    int          exp_n;

    task automatic model(input logic [1:0] op, input logic [29:0] id,
                         input logic [31:0] l1, input logic [31:0] l2, input logic [31:0] l3);
        if (op == 2'd1) begin
            exp_n = 5;
            exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8; exp_a[3] = 32'hC; exp_a[4] = 32'h0;
            exp_d[0] = 32'h0; exp_d[1] = l1;    exp_d[2] = l2;    exp_d[3] = l3;
            exp_d[4] = {id, 2'b01};
        end else if (op == 2'd2) begin
            exp_n = 3;
            exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h0;
            exp_d[0] = 32'h0; exp_d[1] = l1;    exp_d[2] = 32'h2;
        end else begin
            exp_n = 0;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [29:0] id,
                           input logic [31:0] l1, input logic [31:0] l2, input logic [31:0] l3,
                           input int ad, input int wd, input int err_step);
        int base, lat, nw, mx, e_lat, e_ord;
        logic [1:0] e_err;
        model(op, id, l1, l2, l3);
        if (err_step >= exp_n) err_step = -1;
        if (exp_n == 0)          begin nw = 0;            e_err = 2'b10; end
        else if (err_step >= 0)  begin nw = err_step + 1; e_err = 2'b01; end
        else                     begin nw = exp_n;        e_err = 2'b00; end
        mx    = (ad > wd) ? ad : wd;
        e_lat = nw * (mx + 2) + ((nw > 0) ? (nw - 1) * GAP : 0) + 1;
        e_ord = (ad == wd) ? 0 : ((ad > wd) ? 1 : 2);
        aw_dly = ad; w_dly = wd;
        base = obs_addr.size();
        b_err_idx = (err_step >= 0) ? base + err_step : -1;
        chk({tag, " ready"}, 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1; cmd_op = op; cmd_clause_id = id;
        cmd_lit1 = l1; cmd_lit2 = l2; cmd_lit3 = l3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " err"}, 32'(err), 32'(e_err));
        chk({tag, " nwrites"}, obs_addr.size() - base, nw);
        for (int k = 0; k < nw && base + k < obs_addr.size(); k++) begin
            chk($sformatf("%s addr%0d", tag, k), obs_addr[base + k], exp_a[k]);
            chk($sformatf("%s data%0d", tag, k), obs_data[base + k], exp_d[k]);
            chk($sformatf("%s order%0d", tag, k), obs_ord[base + k], e_ord);
        end
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, 32'(done), 32'h0);
        chk({tag, " err_hold"}, 32'(err), 32'(e_err));
        chk({tag, " idle"}, {29'h0, cmd_ready, busy, awvalid | wvalid}, 32'h4);
    endtask

    initial begin : main
        int base, n, r, es;
        logic [1:0] op;
        repeat (3) @(posedge clk);
        #1;
        chk("rst outs", {25'h0, cmd_ready, busy, done, err, awvalid, wvalid}, 32'h40);
        chk("rst bready", 32'(bready), 32'h0);
        chk("rst awaddr", awaddr, 32'h0);
        chk("rst wdata", wdata, 32'h0);
        chk("rst wstrb", 32'(wstrb), 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;

        run_cmd("clause0", 2'd1, 30'd0, 32'h11, 32'h12, 32'h0F, 0, 0, -1);
        run_cmd("decide", 2'd2, 30'd0, 32'h03, 32'h0, 32'h0, 0, 0, -1);
        run_cmd("skew_aw", 2'd1, 30'd7, 32'h21, 32'h30, 32'h45, 3, 0, -1);
        run_cmd("skew_w", 2'd2, 30'd0, 32'h08, 32'h0, 32'h0, 0, 3, -1);
        run_cmd("bresp", 2'd1, 30'd3, 32'h05, 32'h06, 32'h07, 0, 0, 2);
        run_cmd("illegal", 2'd3, 30'd1, 32'h1, 32'h2, 32'h3, 0, 0, -1);

        // reset while the fourth write's response is pending
        aw_dly = 0; w_dly = 0; b_err_idx = -1;
        base = obs_addr.size();
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_clause_id = 30'd9;
        cmd_lit1 = 32'hA1; cmd_lit2 = 32'hA2; cmd_lit3 = 32'hA3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!(bready && obs_addr.size() == base + 4) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_mid reached", 32'(n < 100), 32'h1);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid outs", {25'h0, cmd_ready, busy, done, err, awvalid, wvalid}, 32'h40);
        chk("rst_mid bready", 32'(bready), 32'h0);
        chk("rst_mid axi", awaddr | wdata | 32'(wstrb), 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;
        run_cmd("rst_new", 2'd1, 30'd5, 32'h09, 32'h27, 32'h21, 0, 0, -1);
        chk("rst_new final", obs_data[obs_data.size() - 1], 32'h15);

        // randomized commands with random skew and error injection
        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 9);
            op = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
            es = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
            run_cmd($sformatf("rnd%0d", i), op, 30'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), es);
        end

        chk("stability", stab_bad, 0);
        chk("one_outstanding", ovl_bad, 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
